// File: rtl/prog_count_mc.sv
// Multi-channel programmable counter bank: NCH free-running WIDTH-bit counters with a
// valid/ready ADD/LOAD/SUB/CLEAR command port. Define SATURATE_EN for clamping instead of wrap.
module prog_count_mc #(
  parameter int WIDTH = 5,
  parameter int NCH   = 2,
  parameter int STEP  = 1,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NCH-1:0]         run,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [CHW-1:0]         cmd_ch,
  input  logic [WIDTH-1:0]       cmd_data,
  output logic [NCH*WIDTH-1:0]   out_num,
  output logic [NCH-1:0]         ovf
);

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_APPLY
  } state_e;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [CHW-1:0]   ch_q;
  logic [WIDTH-1:0] data_q;
  logic             accept;

  logic [WIDTH-1:0] cnt_q [NCH];
  logic [WIDTH-1:0] cnt_d [NCH];
  logic [NCH-1:0]   ovf_q, ovf_d;

  // Returns {overflow_event, next_value}; arithmetic is done one bit wider so the
  // top bit is the carry (ADD) or borrow (SUB).
  function automatic logic [WIDTH:0] next_val(input logic [WIDTH-1:0] cnt,
                                               input op_e              op,
                                               input logic [WIDTH-1:0] opnd);
    logic [WIDTH:0] r;
    logic [WIDTH:0] res;
    r   = '0;
    res = '0;
    case (op)
      OP_ADD: begin
        r = {1'b0, cnt} + {1'b0, opnd};
`ifdef SATURATE_EN
        res = r[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : r;
`else
        res = r;
`endif
      end
      OP_SUB: begin
        r = {1'b0, cnt} - {1'b0, opnd};
`ifdef SATURATE_EN
        res = r[WIDTH] ? {1'b1, {WIDTH{1'b0}}} : r;
`else
        res = r;
`endif
      end
      OP_LOAD:  res = {1'b0, opnd};
      OP_CLEAR: res = '0;
      default:  res = '0;
    endcase
    return res;
  endfunction

  assign cmd_ready = (state_q == S_IDLE) && !RST;
  assign accept    = cmd_valid && cmd_ready;

  // NOTE: every signal driven from always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_APPLY;
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      ch_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        ch_q   <= cmd_ch;
        data_q <= cmd_data;
      end
    end
  end

  // A command aimed at a channel index >= NCH matches no channel and is dropped.
  always_comb begin
    logic [WIDTH:0] r;
    r     = '0;
    ovf_d = '0;
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k] = cnt_q[k];
      if ((state_q == S_APPLY) && (int'(ch_q) == k)) begin
        r        = next_val(cnt_q[k], op_q, data_q);
        cnt_d[k] = r[WIDTH-1:0];
        ovf_d[k] = r[WIDTH];
      end else if (run[k]) begin
        r        = next_val(cnt_q[k], OP_ADD, STEP_W);
        cnt_d[k] = r[WIDTH-1:0];
        ovf_d[k] = r[WIDTH];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
      ovf_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) cnt_q[k] <= cnt_d[k];
      ovf_q <= ovf_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign out_num[g*WIDTH +: WIDTH] = cnt_q[g];
  end

  assign ovf = ovf_q;

endmodule
